// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for a combinational 4-bit ALU:
// command handshake, one-cycle execute, show-ahead result FIFO.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [3:0]       i_cmd_op1,
    input  logic [3:0]       i_cmd_op2,
    input  logic [2:0]       i_cmd_ctrl,
    output logic [3:0]       o_alu_op1,
    output logic [3:0]       o_alu_op2,
    output logic [2:0]       o_alu_ctrl,
    input  logic [7:0]       i_alu_dat,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_res_dat,
    output logic             o_res_ill,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t        state;
    logic          ill_q;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic accept;
    logic push;
    logic pop;
    logic not_empty;

    assign not_empty   = (count != '0);
    assign o_cmd_ready = (state == IDLE) && (count < (AW+1)'(DEPTH));
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign push        = (state == EXEC);
    assign pop         = not_empty && i_res_ready;

    assign o_res_valid = not_empty;
    assign o_res_dat   = not_empty ? mem[rd_ptr][7:0] : 8'h00;
    assign o_res_ill   = not_empty ? mem[rd_ptr][8] : 1'b0;
    assign o_busy      = (state == EXEC) || not_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            ill_q      <= 1'b0;
            o_alu_op1  <= '0;
            o_alu_op2  <= '0;
            o_alu_ctrl <= '0;
            o_op_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        o_alu_op1  <= i_cmd_op1;
                        o_alu_op2  <= i_cmd_op2;
                        o_alu_ctrl <= i_cmd_ctrl;
                        ill_q      <= (i_cmd_ctrl > 3'd4);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    o_op_cnt <= o_op_cnt + CNT_W'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem[wr_ptr] <= {ill_q, i_alu_dat};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU model.
// Counter is built 8 bits wide so the wrap is reachable quickly.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op1;
    logic [3:0]       cmd_op2;
    logic [2:0]       cmd_ctrl;
    logic [3:0]       alu_op1;
    logic [3:0]       alu_op2;
    logic [2:0]       alu_ctrl;
    logic [7:0]       alu_dat;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_dat;
    logic             res_ill;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op1  (cmd_op1),
        .i_cmd_op2  (cmd_op2),
        .i_cmd_ctrl (cmd_ctrl),
        .o_alu_op1  (alu_op1),
        .o_alu_op2  (alu_op2),
        .o_alu_ctrl (alu_ctrl),
        .i_alu_dat  (alu_dat),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_dat  (res_dat),
        .o_res_ill  (res_ill),
        .o_busy     (busy),
        .o_op_cnt   (op_cnt)
    );

    // 4-bit ALU: logic/add/sub truncate to 4 bits, mul is full 8 bits.
    logic [3:0] a_sum, a_dif, a_nand, a_nor;
    always_comb begin
        a_sum  = alu_op1 + alu_op2;
        a_dif  = alu_op1 - alu_op2;
        a_nand = ~(alu_op1 & alu_op2);
        a_nor  = ~(alu_op1 | alu_op2);
        alu_dat = 8'h00;
        case (alu_ctrl)
            3'd0:    alu_dat = {4'h0, a_sum};
            3'd1:    alu_dat = {4'h0, a_dif};
            3'd2:    alu_dat = {4'h0, alu_op1} * {4'h0, alu_op2};
            3'd3:    alu_dat = {4'h0, a_nand};
            3'd4:    alu_dat = {4'h0, a_nor};
            default: alu_dat = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] c);
        cmd_op1  = a;
        cmd_op2  = b;
        cmd_ctrl = c;
    endtask

    // Waits (bounded) for ready, then accepts one command and completes it.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] c);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("issue_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        set_cmd(a, b, c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    logic [7:0] t2_exp [4];
    logic [3:0] t2_a   [4];
    logic [3:0] t2_b   [4];
    logic [2:0] t2_c   [4];

    initial begin
        t2_a = '{4'h3, 4'hF, 4'hC, 4'hC};
        t2_b = '{4'h5, 4'hF, 4'hA, 4'hA};
        t2_c = '{3'd1, 3'd2, 3'd3, 3'd4};
        t2_exp = '{8'h0E, 8'hE1, 8'h07, 8'h01};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(4'h0, 4'h0, 3'd0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dat", {24'd0, res_dat}, 32'd0);
        check("rst_ill", {31'd0, res_ill}, 32'd0);
        check("rst_cnt", {24'd0, op_cnt}, 32'd0);
        check("rst_alu", {21'd0, alu_op1, alu_op2, alu_ctrl}, 32'd0);

        // T1: add wrap 7+9
        set_cmd(4'h7, 4'h9, 3'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t1_exec_valid", {31'd0, res_valid}, 32'd0);
        check("t1_exec_ready", {31'd0, cmd_ready}, 32'd0);
        check("t1_exec_busy", {31'd0, busy}, 32'd1);
        check("t1_alu_op1", {28'd0, alu_op1}, 32'h7);
        check("t1_alu_op2", {28'd0, alu_op2}, 32'h9);
        tick();
        check("t1_valid", {31'd0, res_valid}, 32'd1);
        check("t1_dat", {24'd0, res_dat}, 32'h00);
        check("t1_ill", {31'd0, res_ill}, 32'd0);
        check("t1_cnt", {24'd0, op_cnt}, 32'd1);
        check("t1_alu_hold", {28'd0, alu_op1}, 32'h7);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t1_popped", {31'd0, res_valid}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);

        // T2: four legal ops back to back, consumer always ready
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(t2_a[i], t2_b[i], t2_c[i]);
            check("t2_ready_hi", {31'd0, cmd_ready}, 32'd1);
            tick();
            check("t2_ready_lo", {31'd0, cmd_ready}, 32'd0);
            tick();
            check("t2_valid", {31'd0, res_valid}, 32'd1);
            check("t2_dat", {24'd0, res_dat}, {24'd0, t2_exp[i]});
        end
        cmd_valid = 1'b0;
        tick();
        res_ready = 1'b0;
        check("t2_drained", {31'd0, res_valid}, 32'd0);
        check("t2_cnt", {24'd0, op_cnt}, 32'd5);

        // T3: backpressure, five commands with valid held
        cmd_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_cmd(4'(k), 4'h1, 3'd0);
            check("t3_ready_hi", {31'd0, cmd_ready}, 32'd1);
            tick();
            tick();
        end
        check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
        set_cmd(4'h5, 4'h1, 3'd0);
        tick();
        check("t3_stall_ready", {31'd0, cmd_ready}, 32'd0);
        check("t3_stall_alu", {28'd0, alu_op1}, 32'h4);
        check("t3_head", {24'd0, res_dat}, 32'h02);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t3_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("t3_accept5", {28'd0, alu_op1}, 32'h5);
        tick();
        check("t3_cnt", {24'd0, op_cnt}, 32'd10);
        res_ready = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            check("t3_order", {23'd0, res_valid, res_dat}, 32'h100 | k);
            tick();
        end
        res_ready = 1'b0;
        check("t3_empty", {31'd0, res_valid}, 32'd0);

        // T4: illegal opcode then legal add
        issue(4'hF, 4'hF, 3'd6);
        check("t4_ill_dat", {24'd0, res_dat}, 32'h00);
        check("t4_ill_flag", {31'd0, res_ill}, 32'd1);
        check("t4_ill_ctrl", {29'd0, alu_ctrl}, 32'd6);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        issue(4'h1, 4'h1, 3'd0);
        check("t4_add_dat", {24'd0, res_dat}, 32'h02);
        check("t4_add_ill", {31'd0, res_ill}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // T5: reset during EXEC with two entries queued
        issue(4'h2, 4'h3, 3'd0);
        issue(4'h4, 4'h3, 3'd1);
        set_cmd(4'h6, 4'h6, 3'd2);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t5_pre_busy", {31'd0, busy}, 32'd1);
        check("t5_pre_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", {31'd0, res_valid}, 32'd0);
        check("t5_cnt", {24'd0, op_cnt}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_ready", {31'd0, cmd_ready}, 32'd1);
        check("t5_alu", {21'd0, alu_op1, alu_op2, alu_ctrl}, 32'd0);
        tick();
        check("t5_no_push", {31'd0, res_valid}, 32'd0);

        // T6: push and pop together at count DEPTH-1
        for (int k = 1; k <= 3; k++) begin
            issue(4'(k), 4'h0, 3'd0);
        end
        set_cmd(4'h4, 4'h0, 3'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t6_ready", {31'd0, cmd_ready}, 32'd1);
        check("t6_cnt", {24'd0, op_cnt}, 32'd4);
        res_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            check("t6_order", {23'd0, res_valid, res_dat}, 32'h100 | k);
            tick();
        end
        check("t6_empty", {31'd0, res_valid}, 32'd0);

        // Counter wrap: advance to 2^CNT_W-1, then one more push
        cmd_valid = 1'b1;
        set_cmd(4'h1, 4'h2, 3'd0);
        for (int i = 0; i < (1 << CNT_W) - 1 - 4; i++) begin
            tick();
            tick();
        end
        cmd_valid = 1'b0;
        check("wrap_max", {24'd0, op_cnt}, 32'hFF);
        issue(4'h1, 4'h2, 3'd0);
        check("wrap_zero", {24'd0, op_cnt}, 32'd0);
        check("wrap_dat", {24'd0, res_dat}, 32'h03);
        tick();
        res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
